// File: rtl/proc_mem_arbiter_if.sv
// Message formats and the val/rdy channel interface shared by the
// processor memory arbiter and its environment.
//   mem_msg_pkg          : 4-byte memory request/response message structs
//   proc_mem_arbiter_if  : one val/rdy channel carrying a W-bit message
//     master : drives msg/val, receives rdy
//     slave  : receives msg/val, drives rdy
package mem_msg_pkg;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

endpackage

interface proc_mem_arbiter_if #(parameter int W = 1);
  logic [W-1:0] msg;
  logic         val;
  logic         rdy;

  modport master (output msg, output val, input rdy);
  modport slave  (input msg, input val, output rdy);
endinterface

// File: rtl/proc_mem_arbiter.sv
// Shares one unified memory port between the imem (port 0) and dmem (port 1)
// requesters. Requests are arbitrated round-robin and passed through with zero
// latency; the grantee of each accepted request is pushed into an in-order ID
// FIFO so the in-order memory responses can be steered back to their issuer.
// Ports:
//   clk, reset      : clock; asynchronous active-low reset
//   req0, req1      : slave channels from imem/dmem (mem_req_4B_t)
//   resp0, resp1    : master channels back to imem/dmem (mem_resp_4B_t)
//   memreq          : master channel to the unified memory (mem_req_4B_t)
//   memresp         : slave channel from the unified memory (mem_resp_4B_t)
//   num_outstanding : accepted requests still awaiting a response
module proc_mem_arbiter #(
  parameter int p_max_outstanding = 4,
  parameter int p_ptr_nbits       = $clog2(p_max_outstanding)
) (
  input  logic                     clk,
  input  logic                     reset,
  proc_mem_arbiter_if.slave        req0,
  proc_mem_arbiter_if.slave        req1,
  proc_mem_arbiter_if.master       resp0,
  proc_mem_arbiter_if.master       resp1,
  proc_mem_arbiter_if.master       memreq,
  proc_mem_arbiter_if.slave        memresp,
  output logic [p_ptr_nbits:0]     num_outstanding
);

  localparam logic [p_ptr_nbits:0] DEPTH = (p_ptr_nbits+1)'(p_max_outstanding);

  logic                         prio;
  logic [p_max_outstanding-1:0] ids;
  logic [p_ptr_nbits-1:0]       wr_ptr, rd_ptr;
  logic [p_ptr_nbits:0]         count;

  logic full, empty, head;
  logic gnt, gnt_vld;
  logic push, pop;

  assign full  = (count == DEPTH);
  assign empty = (count == '0);
  assign head  = ids[rd_ptr];

  // ---------------------------------------------------------------- request
  // A lone valid port wins outright; prio only breaks ties. Default grant is
  // port 0 so memreq.msg shows req0 when nobody is asking.
  assign gnt_vld = req0.val | req1.val;
  assign gnt     = (req0.val & req1.val) ? prio : req1.val;

  // full is based on count alone (not count minus a same-cycle pop), which
  // keeps the memresp side out of the request path.
  assign memreq.val = gnt_vld & ~full;
  assign memreq.msg = gnt ? req1.msg : req0.msg;

  assign req0.rdy = gnt_vld & ~gnt & memreq.rdy & ~full;
  assign req1.rdy = gnt_vld &  gnt & memreq.rdy & ~full;

  assign push = memreq.val & memreq.rdy;

  // --------------------------------------------------------------- response
  assign resp0.msg = memresp.msg;
  assign resp1.msg = memresp.msg;
  assign resp0.val = memresp.val & ~empty & ~head;
  assign resp1.val = memresp.val & ~empty &  head;

  // Only the head requester's ready may consume the response.
  assign memresp.rdy = ~empty & (head ? resp1.rdy : resp0.rdy);

  assign pop = memresp.val & memresp.rdy;

  // ------------------------------------------------------------------ state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio   <= 1'b1;
      ids    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        ids[wr_ptr] <= gnt;
        wr_ptr      <= wr_ptr + 1'b1;
        // Favour the loser next time: a port held valid while losing is
        // served on the very next accept.
        prio        <= ~gnt;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign num_outstanding = count;

  // A response with nothing outstanding has no owner; it is left unconsumed.
  a_resp_without_req: assert property (
    @(posedge clk) disable iff (!reset) !(memresp.val && empty)
  ) else $error("proc_mem_arbiter: memory response with no outstanding request");

endmodule

// File: tb/tb_proc_mem_arbiter.sv
module tb_proc_mem_arbiter;
  import mem_msg_pkg::*;

  localparam int RQW = $bits(mem_req_4B_t);
  localparam int RSW = $bits(mem_resp_4B_t);

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] num_outstanding;

  always #5 clk = ~clk;

  proc_mem_arbiter_if #(.W(RQW)) req0_if ();
  proc_mem_arbiter_if #(.W(RQW)) req1_if ();
  proc_mem_arbiter_if #(.W(RSW)) resp0_if ();
  proc_mem_arbiter_if #(.W(RSW)) resp1_if ();
  proc_mem_arbiter_if #(.W(RQW)) memreq_if ();
  proc_mem_arbiter_if #(.W(RSW)) memresp_if ();

  proc_mem_arbiter #(.p_max_outstanding(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .req0            (req0_if),
    .req1            (req1_if),
    .resp0           (resp0_if),
    .resp1           (resp1_if),
    .memreq          (memreq_if),
    .memresp         (memresp_if),
    .num_outstanding (num_outstanding)
  );

  typedef struct {
    logic r0v, r1v, mrdy, p0rdy, p1rdy, mrv;
    logic e_mval, e_gnt, e_r0rdy, e_r1rdy, e_p0v, e_p1v, e_mrdy;
    logic [2:0] e_cnt;
  } vec_t;

  int total = 0;
  int bad   = 0;

  mem_req_4B_t  m0, m1;
  mem_resp_4B_t mr;
  vec_t         q[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r0v, r1v, mrdy, p0rdy, p1rdy, mrv,
                              input logic e_mval, e_gnt, e_r0rdy, e_r1rdy,
                              input logic e_p0v, e_p1v, e_mrdy,
                              input logic [2:0] e_cnt);
    vec_t v;
    v.r0v = r0v; v.r1v = r1v; v.mrdy = mrdy; v.p0rdy = p0rdy; v.p1rdy = p1rdy;
    v.mrv = mrv; v.e_mval = e_mval; v.e_gnt = e_gnt; v.e_r0rdy = e_r0rdy;
    v.e_r1rdy = e_r1rdy; v.e_p0v = e_p0v; v.e_p1v = e_p1v; v.e_mrdy = e_mrdy;
    v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic drive(input logic r0v, r1v, mrdy, p0rdy, p1rdy, mrv);
    req0_if.val    = r0v;
    req1_if.val    = r1v;
    memreq_if.rdy  = mrdy;
    resp0_if.rdy   = p0rdy;
    resp1_if.rdy   = p1rdy;
    memresp_if.val = mrv;
  endtask

  // Drive at the falling edge, sample 1 time unit later: state reflects the
  // preceding rising edge, outputs reflect the new inputs.
  task automatic step(input logic r0v, r1v, mrdy, p0rdy, p1rdy, mrv);
    @(negedge clk);
    drive(r0v, r1v, mrdy, p0rdy, p1rdy, mrv);
    #1;
  endtask

  initial begin
    m0 = '0; m0.type_ = 3'd0; m0.opaque = 8'h5a; m0.addr = 32'h200;  m0.data = 32'h0;
    m1 = '0; m1.type_ = 3'd1; m1.opaque = 8'h11; m1.addr = 32'h1000; m1.data = 32'hcafe0001;
    mr = '0; mr.opaque = 8'h5a; mr.data = 32'hdeadbeef;
    req0_if.msg    = m0;
    req1_if.msg    = m1;
    memresp_if.msg = mr;
    drive(0, 0, 0, 1, 1, 0);

    //          r0v r1v mrdy p0r p1r mrv | mval gnt r0rdy r1rdy p0v p1v mrdy cnt
    // single imem request, then its response
    q.push_back(mk(1,0,1,1,1,0, 1,0,1,0,0,0,0,0));
    q.push_back(mk(0,0,1,1,1,1, 0,0,0,0,1,0,1,1));
    q.push_back(mk(0,0,1,1,1,0, 0,0,0,0,0,0,0,0));
    // both valid: grants 1,0,1,0,1; responses two cycles behind
    q.push_back(mk(1,1,1,1,1,0, 1,1,0,1,0,0,0,0));
    q.push_back(mk(1,1,1,1,1,0, 1,0,1,0,0,0,1,1));
    q.push_back(mk(1,1,1,1,1,1, 1,1,0,1,0,1,1,2));
    q.push_back(mk(1,1,1,1,1,1, 1,0,1,0,1,0,1,2));
    q.push_back(mk(1,1,1,1,1,1, 1,1,0,1,0,1,1,2));
    q.push_back(mk(0,0,1,1,1,1, 0,0,0,0,1,0,1,2));
    q.push_back(mk(0,0,1,1,1,1, 0,0,0,0,0,1,1,1));
    // fill to 4, fifth blocked even on the popping cycle, accepted next
    q.push_back(mk(1,0,1,1,1,0, 1,0,1,0,0,0,0,0));
    q.push_back(mk(1,0,1,1,1,0, 1,0,1,0,0,0,1,1));
    q.push_back(mk(1,0,1,1,1,0, 1,0,1,0,0,0,1,2));
    q.push_back(mk(1,0,1,1,1,0, 1,0,1,0,0,0,1,3));
    q.push_back(mk(1,0,1,1,1,0, 0,0,0,0,0,0,1,4));
    q.push_back(mk(1,0,1,1,1,1, 0,0,0,0,1,0,1,4));
    q.push_back(mk(1,0,1,1,1,0, 1,0,1,0,0,0,1,3));
    q.push_back(mk(0,0,1,1,1,1, 0,0,0,0,1,0,1,4));
    q.push_back(mk(0,0,1,1,1,1, 0,0,0,0,1,0,1,3));
    q.push_back(mk(0,0,1,1,1,1, 0,0,0,0,1,0,1,2));
    q.push_back(mk(0,0,1,1,1,1, 0,0,0,0,1,0,1,1));
    q.push_back(mk(0,0,1,1,1,0, 0,0,0,0,0,0,0,0));

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt", num_outstanding, 0);
    chk("rst_mrdy", memresp_if.rdy, 0);
    chk("rst_mval", memreq_if.val, 0);
    @(negedge clk);
    reset = 1'b1;

    foreach (q[i]) begin
      step(q[i].r0v, q[i].r1v, q[i].mrdy, q[i].p0rdy, q[i].p1rdy, q[i].mrv);
      chk($sformatf("v%0d_mval", i),  memreq_if.val,  q[i].e_mval);
      chk($sformatf("v%0d_msg", i),   memreq_if.msg,  q[i].e_gnt ? m1 : m0);
      chk($sformatf("v%0d_r0rdy", i), req0_if.rdy,    q[i].e_r0rdy);
      chk($sformatf("v%0d_r1rdy", i), req1_if.rdy,    q[i].e_r1rdy);
      chk($sformatf("v%0d_p0v", i),   resp0_if.val,   q[i].e_p0v);
      chk($sformatf("v%0d_p1v", i),   resp1_if.val,   q[i].e_p1v);
      chk($sformatf("v%0d_mrdy", i),  memresp_if.rdy, q[i].e_mrdy);
      chk($sformatf("v%0d_cnt", i),   num_outstanding, q[i].e_cnt);
      if (q[i].mrv) begin
        chk($sformatf("v%0d_p0msg", i), resp0_if.msg, mr);
        chk($sformatf("v%0d_p1msg", i), resp1_if.msg, mr);
      end
    end

    // head owned by port 0 is held while resp0_rdy is low
    step(1, 0, 1, 1, 1, 0);
    chk("hold_push", req0_if.rdy, 1);
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 1, 0, 1, 1);
      chk("hold_mrdy", memresp_if.rdy, 0);
      chk("hold_p1v",  resp1_if.val, 0);
      chk("hold_p0v",  resp0_if.val, 1);
      chk("hold_cnt",  num_outstanding, 1);
    end
    step(0, 0, 1, 1, 1, 1);
    chk("rel_mrdy", memresp_if.rdy, 1);
    step(0, 0, 1, 1, 1, 0);
    chk("rel_cnt", num_outstanding, 0);

    // reset with three outstanding
    repeat (3) step(1, 0, 1, 1, 1, 0);
    step(0, 0, 1, 1, 1, 0);
    chk("pre_rst_cnt", num_outstanding, 3);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_cnt", num_outstanding, 0);
    chk("mid_rst_mrdy", memresp_if.rdy, 0);
    @(negedge clk);
    reset = 1'b1;

    // both valid, memory stalled: no accept, prio stays on port 1
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 0, 1, 1, 0);
      chk("stall_mval",  memreq_if.val, 1);
      chk("stall_msg",   memreq_if.msg, m1);
      chk("stall_r0rdy", req0_if.rdy, 0);
      chk("stall_r1rdy", req1_if.rdy, 0);
      chk("stall_cnt",   num_outstanding, 0);
    end
    step(1, 1, 1, 1, 1, 0);
    chk("go_r1rdy", req1_if.rdy, 1);
    chk("go_r0rdy", req0_if.rdy, 0);
    step(1, 1, 1, 1, 1, 0);
    chk("next_r0rdy", req0_if.rdy, 1);
    chk("next_r1rdy", req1_if.rdy, 0);
    chk("next_cnt",   num_outstanding, 1);
    step(0, 0, 1, 1, 1, 1);
    chk("drain_p1v", resp1_if.val, 1);
    step(0, 0, 1, 1, 1, 1);
    chk("drain_p0v", resp0_if.val, 1);
    step(0, 0, 1, 1, 1, 0);
    chk("drain_cnt", num_outstanding, 0);

    // stray response with empty FIFO: shown only between clock edges
    memresp_if.val = 1'b1;
    #1;
    chk("stray_mrdy", memresp_if.rdy, 0);
    chk("stray_p0v",  resp0_if.val, 0);
    chk("stray_p1v",  resp1_if.val, 0);
    memresp_if.val = 1'b0;
    step(0, 0, 1, 1, 1, 0);
    chk("final_cnt", num_outstanding, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/proc_mem_arbiter.md
Name: proc_mem_arbiter

Overview:
- Shares one unified memory port between the processor's instruction-fetch requester (port 0) and data requester (port 1).
- Sits between the processor's imem/dmem bypass queues and a single-ported test memory or cache.
- Arbitrates requests round-robin and records the grantee of each accepted request in an in-order ID FIFO.
- Routes each in-order memory response back to the requester that issued it.

Parameters:
- p_max_outstanding, 4, max accepted requests awaiting response; power of two, >=2
- p_ptr_nbits, $clog2(p_max_outstanding), ID FIFO pointer width

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset; state clears while low
- req0_msg  input  $bits(mem_req_4B_t)  imem request
- req0_val  input  1  imem request valid
- req0_rdy  output  1  imem request ready
- req1_msg  input  $bits(mem_req_4B_t)  dmem request
- req1_val  input  1  dmem request valid
- req1_rdy  output  1  dmem request ready
- resp0_msg  output  $bits(mem_resp_4B_t)  imem response
- resp0_val  output  1  imem response valid
- resp0_rdy  input  1  imem response ready
- resp1_msg  output  $bits(mem_resp_4B_t)  dmem response
- resp1_val  output  1  dmem response valid
- resp1_rdy  input  1  dmem response ready
- memreq_msg  output  $bits(mem_req_4B_t)  unified request
- memreq_val  output  1  unified request valid
- memreq_rdy  input  1  unified request ready
- memresp_msg  input  $bits(mem_resp_4B_t)  unified response, in request order
- memresp_val  input  1  unified response valid
- memresp_rdy  output  1  unified response ready
- num_outstanding  output  p_ptr_nbits+1  ID FIFO occupancy

Behaviour:
State:
- prio: 1 bit; 0 favours port 0; reset value 1, so dmem is favoured first.
- ID FIFO: p_max_outstanding x 1 bit, holding grantee IDs.
- Pointers: wr_ptr and rd_ptr, each p_ptr_nbits wide; wrap modulo depth.
- Occupancy: count, p_ptr_nbits+1 wide.
- While reset is low: count=0, pointers=0, prio=1, ID entries cleared.

Request path (combinational, zero latency):
- full = (count == p_max_outstanding).
- Grant:
  - Only one port valid: that port wins.
  - Both valid: port prio wins.
  - Neither valid: no grant.
- memreq_val = granted port's val & !full.
- memreq_msg = granted port's msg, passed through unmodified, opaque included. When no grant it equals req0_msg.
- reqN_rdy = (grant==N) & memreq_rdy & !full. The loser's rdy=0.
- No combinational path from any rdy input to any val output of the same port.
- Accepted request (memreq_val & memreq_rdy):
  - Push grantee ID at wr_ptr; wr_ptr++.
  - prio <= ~grantee.
- prio is unchanged on cycles with no accept. A port held valid while losing is served next accept, so starvation is bounded to 1 transaction.

Response path (combinational routing):
- empty = (count == 0). head = ID at rd_ptr.
- respN_msg = memresp_msg for both N.
- respN_val = memresp_val & !empty & (head==N).
- memresp_rdy = !empty & resp[head]_rdy.
- Response with empty FIFO: memresp_rdy=0 and both resp_val=0. The response is not consumed; this is a protocol error, asserted in simulation with $error.
- Accepted response (memresp_val & memresp_rdy): rd_ptr++.

Occupancy and boundaries:
- count changes by +1 on push only, -1 on pop only, 0 on simultaneous push and pop.
- When full, new requests are blocked even if a pop occurs that cycle. This keeps memresp out of the request path.
- num_outstanding = count.
- Pointer wrap from p_max_outstanding-1 to 0 is seamless.
- Reset asserted mid-transaction: all outstanding IDs are discarded. Memory responses arriving after reset release are treated as empty-FIFO responses.

Latency: 0 cycles request and response (pure pass-through), plus the 1-cycle state update.

Test Plan:
- Only req0 valid, addr 0x200, memreq_rdy=1 -> memreq_msg.addr=0x200 same cycle, req0_rdy=1. Memory response data 0xdeadbeef -> resp0_val=1, resp1_val=0, count returns 0.
- Both valid every cycle, memreq_rdy=1, memory responds 2 cycles later -> grants 1,0,1,0,1 from reset. Each response is routed to the matching port in issue order.
- Both valid, memreq_rdy=0 for 3 cycles -> no accept, prio stays 1, req0_rdy=req1_rdy=0. When ready rises, port 1 is accepted first.
- Issue 4 requests with no responses (count=4) -> memreq_val=0, rdy=0. A fifth request is blocked, including on the cycle a response pops. It is accepted the next cycle.
- Head ID=0 with resp0_rdy=0 and resp1_rdy=1 -> memresp_rdy=0 and resp1_val=0; the response is held until resp0_rdy=1.
- Drop reset low with count=3, then release -> count=0, num_outstanding=0, and the next simultaneous request grants port 1. A memresp_val with the FIFO empty yields memresp_rdy=0.
